smg_scan_param_zyq: RTL and testbench

Parametrised multiplexed seven-segment scan driver. It is the successor of the fixed 8-digit scanner, sitting between the datapath register that holds the displayed value and the board's digit-select and segment pins. New over the old scanner: configurable digit count and scan rate, and double-buffered loading with frame-boundary update (no tearing). It also adds per-digit decimal points, leading-zero suppression, PWM brightness and a frame-done pulse.

---
 rtl/smg_pkg_zyq.sv | 23 ++
 rtl/smg_scan_param_zyq_if.sv | 26 ++
 rtl/seg_decode_zyq.sv | 13 +
 rtl/smg_scan_param_zyq.sv | 108 ++++++++++
 tb/tb_smg_scan_param_zyq.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/smg_pkg_zyq.sv
// Shared constants for the parametrised seven-segment scanner.
// Segment table is {a,b,c,d,e,f,g}, active-high.
package smg_pkg_zyq;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [15:0][6:0] SEG_TAB = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,
    7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33,
    7'h79, 7'h6D, 7'h30, 7'h7E
  };

  // Never returns less than 1 so counters keep at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/smg_scan_param_zyq_if.sv
// Datapath-side and pin-side signals of the scan driver.
// The datapath is the master, the scanner is the slave.
interface smg_scan_param_zyq_if #(
  parameter int DIGITS = 8,
  parameter int DUTY_W = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   datain;
  logic [DIGITS-1:0]     dpin;
  logic                  lz_en;
  logic [DUTY_W-1:0]     bright;
  logic [DIGITS-1:0]     ledcs;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_done;

  modport master (
    output load, datain, dpin, lz_en, bright,
    input  ledcs, seg, dp, frame_done
  );

  modport slave (
    input  load, datain, dpin, lz_en, bright,
    output ledcs, seg, dp, frame_done
  );
endinterface

// File: rtl/seg_decode_zyq.sv
// Hex nibble to active-high segments, with blanking.
// Purely combinational; used once on the selected digit.
module seg_decode_zyq
  import smg_pkg_zyq::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : SEG_TAB[nib];

endmodule

// File: rtl/smg_scan_param_zyq.sv
// Multiplexed seven-segment scanner with double-buffered
// frame-boundary loading, zero suppression and PWM dimming.
module smg_scan_param_zyq
  import smg_pkg_zyq::*;
#(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int DUTY_W     = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  smg_scan_param_zyq_if.slave bus
);

  localparam int CW = clog2(SCAN_DIV);
  localparam int IW = clog2(DIGITS);
  localparam int PW = CW + DUTY_W + 1;

  if (DIGITS < 2 || DIGITS > 16 || SCAN_DIV < 2 || DUTY_W < 1)
  begin : g_bad_param
    $error("smg_scan_param_zyq: illegal parameter value");
  end

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] act_d;
  logic [4*DIGITS-1:0] pend_d;
  logic [DIGITS-1:0]   act_p;
  logic [DIGITS-1:0]   pend_p;
  logic                pend_v;

  logic [DIGITS-1:0]   cs_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic                fd_q;

  logic                slot_end;
  logic                frame_end;
  logic [4*DIGITS-1:0] hi;
  logic [3:0]          nib;
  logic                blank;
  logic [6:0]          segd;
  logic [PW-1:0]       lhs;
  logic [PW-1:0]       rhs;
  logic [DIGITS-1:0]   sel;

  assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(DIGITS - 1));

  // hi holds nibbles idx..DIGITS-1; all zero means suppressible.
  always_comb begin
    hi    = act_d >> {idx, 2'b00};
    nib   = hi[3:0];
    blank = bus.lz_en && (idx != '0) && (hi == '0);
    lhs   = PW'(cnt) << DUTY_W;
    rhs   = (PW'(bus.bright) + PW'(1)) * PW'(SCAN_DIV);
    sel   = (lhs < rhs) ? (DIGITS'(1) << idx) : '0;
  end

  seg_decode_zyq u_dec (
    .nib   (nib),
    .blank (blank),
    .seg   (segd)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt    <= '0;
      idx    <= '0;
      act_d  <= '0;
      act_p  <= '0;
      pend_d <= '0;
      pend_p <= '0;
      pend_v <= 1'b0;
      cs_q   <= {DIGITS{ACTIVE_LOW}};
      seg_q  <= {7{ACTIVE_LOW}};
      dp_q   <= ACTIVE_LOW;
      fd_q   <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end)
        idx <= frame_end ? '0 : idx + IW'(1);
      if (frame_end && pend_v) begin
        act_d <= pend_d;
        act_p <= pend_p;
      end
      // A load on the boundary keeps pend_v set for the next frame.
      if (bus.load) begin
        pend_d <= bus.datain;
        pend_p <= bus.dpin;
        pend_v <= 1'b1;
      end else if (frame_end) begin
        pend_v <= 1'b0;
      end
      cs_q  <= sel ^ {DIGITS{ACTIVE_LOW}};
      seg_q <= segd ^ {7{ACTIVE_LOW}};
      dp_q  <= act_p[idx] ^ ACTIVE_LOW;
      fd_q  <= frame_end;
    end
  end

  assign bus.ledcs      = cs_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_smg_scan_param_zyq.sv
// Directed vectors for the scanner: DIGITS=8, SCAN_DIV=4,
// DUTY_W=2, active-low pins, 32-clock frames.
module tb_smg_scan_param_zyq;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  smg_scan_param_zyq_if #(.DIGITS(8), .DUTY_W(2)) bus ();

  smg_scan_param_zyq #(
    .DIGITS(8), .SCAN_DIV(4), .DUTY_W(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0]     data;
    logic [7:0]      dpin;
    logic            lz;
    logic [1:0]      bright;
    int              on;
    logic [7:0][6:0] eseg;
    logic [7:0]      edp;
  } vec_t;

  vec_t vt [8];
  vec_t vz, va, vb;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  task automatic wait_fd(input string n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (bus.frame_done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s frame_done timeout act=0 exp=1", n);
    end
  endtask

  // Starts right after a frame_done sample; ends on the next one.
  task automatic check_frame(input vec_t v, input string n);
    logic [7:0] ecs;
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge CLK);
        ecs = 8'hFF;
        if (c < v.on) ecs = ~(8'(1) << d);
        chk($sformatf("%s d%0d c%0d ledcs", n, d, c),
            32'(bus.ledcs), 32'(ecs));
        chk($sformatf("%s d%0d c%0d seg", n, d, c),
            32'(bus.seg), 32'(v.eseg[d]));
        chk($sformatf("%s d%0d c%0d dp", n, d, c),
            32'(bus.dp), 32'(v.edp[d]));
        chk($sformatf("%s d%0d c%0d fd", n, d, c),
            32'(bus.frame_done), 32'(d == 7 && c == 3));
      end
    end
  endtask

  task automatic drive_load(input vec_t v);
    bus.datain = v.data;
    bus.dpin   = v.dpin;
    bus.lz_en  = v.lz;
    bus.bright = v.bright;
    bus.load   = 1'b1;
    @(negedge CLK);
    bus.load   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vt[0] = '{32'h76543210, 8'h00, 1'b0, 2'd3, 4,
      {7'h0F,7'h20,7'h24,7'h4C,7'h06,7'h12,7'h4F,7'h01}, 8'hFF};
    vt[1] = '{32'h00000A05, 8'h00, 1'b1, 2'd3, 4,
      {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h08,7'h01,7'h24}, 8'hFF};
    vt[2] = '{32'h00000A05, 8'h00, 1'b0, 2'd3, 4,
      {7'h01,7'h01,7'h01,7'h01,7'h01,7'h08,7'h01,7'h24}, 8'hFF};
    vt[3] = '{32'hFEDCBA98, 8'hAA, 1'b0, 2'd0, 1,
      {7'h38,7'h30,7'h42,7'h31,7'h60,7'h08,7'h04,7'h00}, 8'h55};
    vt[4] = '{32'h00000000, 8'h01, 1'b1, 2'd3, 4,
      {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h01}, 8'hFE};
    vt[5] = '{32'h00000000, 8'h08, 1'b1, 2'd3, 4,
      {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h01}, 8'hF7};
    vt[6] = '{32'h00100000, 8'h00, 1'b1, 2'd1, 2,
      {7'h7F,7'h7F,7'h4F,7'h01,7'h01,7'h01,7'h01,7'h01}, 8'hFF};
    vt[7] = '{32'h0000C0D0, 8'h00, 1'b1, 2'd2, 3,
      {7'h7F,7'h7F,7'h7F,7'h7F,7'h31,7'h01,7'h42,7'h01}, 8'hFF};
    vz = '{32'h00000000, 8'h00, 1'b0, 2'd3, 4,
      {7'h01,7'h01,7'h01,7'h01,7'h01,7'h01,7'h01,7'h01}, 8'hFF};
    va = '{32'h11111111, 8'h00, 1'b0, 2'd3, 4,
      {7'h4F,7'h4F,7'h4F,7'h4F,7'h4F,7'h4F,7'h4F,7'h4F}, 8'hFF};
    vb = '{32'h22222222, 8'hFF, 1'b0, 2'd3, 4,
      {7'h12,7'h12,7'h12,7'h12,7'h12,7'h12,7'h12,7'h12}, 8'h00};

    bus.load   = 1'b0;
    bus.datain = '0;
    bus.dpin   = '0;
    bus.lz_en  = 1'b0;
    bus.bright = 2'd3;
    RST = 1'b1;
    #1 RST = 1'b0;

    repeat (2) @(negedge CLK);
    chk("reset ledcs", 32'(bus.ledcs), 32'hFF);
    chk("reset seg", 32'(bus.seg), 32'h7F);
    chk("reset dp", 32'(bus.dp), 32'h1);
    chk("reset fd", 32'(bus.frame_done), 32'h0);

    RST = 1'b1;
    check_frame(vz, "first");

    foreach (vt[i]) begin
      drive_load(vt[i]);
      wait_fd($sformatf("v%0d", i));
      check_frame(vt[i], $sformatf("v%0d", i));
    end

    // Load B on the boundary edge while A is pending.
    drive_load(va);
    repeat (30) @(negedge CLK);
    bus.datain = vb.data;
    bus.dpin   = vb.dpin;
    bus.load   = 1'b1;
    @(negedge CLK);
    bus.load   = 1'b0;
    chk("coinc fd", 32'(bus.frame_done), 32'h1);
    check_frame(va, "coincA");
    check_frame(vb, "coincB");

    // Mid-frame reset discards pending data.
    bus.lz_en  = 1'b0;
    bus.bright = 2'd3;
    bus.datain = 32'h99999999;
    bus.dpin   = 8'hFF;
    bus.load   = 1'b1;
    @(negedge CLK);
    bus.load   = 1'b0;
    repeat (5) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("async ledcs", 32'(bus.ledcs), 32'hFF);
    chk("async seg", 32'(bus.seg), 32'h7F);
    chk("async dp", 32'(bus.dp), 32'h1);
    chk("async fd", 32'(bus.frame_done), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    check_frame(vz, "rst1");
    check_frame(vz, "rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
